// File: rtl/glyph_pixel_pipe.sv
// Pixel-to-glyph pipeline: maps each sync-generator pixel to a character cell, addresses the
// glyph ROMs through the external pointer table and emits one registered colour with aligned syncs.
module glyph_pixel_pipe #(
   parameter int unsigned CELL_W    = 32,
   parameter int unsigned CELL_H    = 60,
   parameter int unsigned LBL_H     = 20,
   parameter int unsigned NUM_CELLS = 8,
   parameter int unsigned ORIGIN_X  = 64,
   parameter int unsigned ORIGIN_Y  = 200,
   parameter logic [7:0]  FG_COLOR  = 8'hFF,
   parameter logic [7:0]  BG_COLOR  = 8'h00
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [9:0]             pixel_x,
   input  logic [9:0]             pixel_y,
   input  logic                   video_on,
   input  logic                   hsync_in,
   input  logic                   vsync_in,
   input  logic [4*NUM_CELLS-1:0] cell_values,
   output logic [3:0]             value_sel,
   input  logic [9:0]             point_y,
   input  logic [1:0]             chip_sel,
   output logic [9:0]             rom_addr,
   output logic                   rom_en_digit,
   output logic                   rom_en_label,
   output logic                   rom_en_ind,
   input  logic [CELL_W-1:0]      rom_data,
   output logic [7:0]             rgb,
   output logic                   hsync_out,
   output logic                   vsync_out,
   output logic                   video_on_out
);
   localparam int unsigned CB   = $clog2(CELL_W);
   localparam int unsigned CI   = $clog2(NUM_CELLS);
   localparam int unsigned X_HI = ORIGIN_X + NUM_CELLS * CELL_W;
   localparam int unsigned Y_HI = ORIGIN_Y + CELL_H;

   logic [9:0]       r_x, r_y;
   logic             r_vid0, r_hs0, r_vs0;
   logic [3:0]       r_snap [NUM_CELLS];

   logic             w_in_reg;
   logic [CB+CI-1:0] w_xoff;
   logic [CI-1:0]    w_cell;
   logic [CB-1:0]    w_col;
   logic [9:0]       w_row;
   logic             w_lbl_ok;
   logic             w_en_d, w_en_l, w_en_i;
   logic             w_blank;
   logic [CB-1:0]    w_bit;

   logic [CB-1:0]    r_col1, r_col2;
   logic             r_blank1, r_blank2;
   logic             r_hs1, r_hs2, r_vs1, r_vs2, r_vid1, r_vid2;

   // Stage 0: pixel registers; snapshot taken when the registered vsync sees a 1->0 fall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_vid0 <= 1'b0;
         r_hs0  <= 1'b1;
         r_vs0  <= 1'b1;
         for (int unsigned i = 0; i < NUM_CELLS; i++) r_snap[i] <= 4'hF;
      end else begin
         r_x    <= pixel_x;
         r_y    <= pixel_y;
         r_vid0 <= video_on;
         r_hs0  <= hsync_in;
         r_vs0  <= vsync_in;
         if (r_vs0 && !vsync_in) begin
            for (int unsigned i = 0; i < NUM_CELLS; i++) r_snap[i] <= cell_values[4*i +: 4];
         end
      end
   end

   assign w_in_reg = r_vid0
                  && (32'(r_x) >= ORIGIN_X) && (32'(r_x) < X_HI)
                  && (32'(r_y) >= ORIGIN_Y) && (32'(r_y) < Y_HI);
   assign w_xoff   = (CB+CI)'(r_x - 10'(ORIGIN_X));
   assign {w_cell, w_col} = w_xoff;
   assign w_row    = r_y - 10'(ORIGIN_Y);
   assign value_sel = w_in_reg ? r_snap[w_cell] : 4'hF;

   always_comb begin
      w_en_d   = 1'b0;
      w_en_l   = 1'b0;
      w_en_i   = 1'b0;
      w_lbl_ok = (32'(w_row) < LBL_H);
      if (w_in_reg) begin
         case (chip_sel)
            2'b01:   w_en_d = 1'b1;
            2'b10:   w_en_l = w_lbl_ok;
            2'b11:   w_en_i = w_lbl_ok;
            default: ;
         endcase
      end
   end

   assign w_blank = !(w_en_d || w_en_l || w_en_i);
   // CELL_W is a power of two, so CELL_W-1-col is the bitwise complement of col
   assign w_bit   = ~r_col2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr     <= '0;
         rom_en_digit <= 1'b0;
         rom_en_label <= 1'b0;
         rom_en_ind   <= 1'b0;
         r_col1       <= '0;
         r_col2       <= '0;
         r_blank1     <= 1'b1;
         r_blank2     <= 1'b1;
         r_hs1        <= 1'b1;
         r_hs2        <= 1'b1;
         r_vs1        <= 1'b1;
         r_vs2        <= 1'b1;
         r_vid1       <= 1'b0;
         r_vid2       <= 1'b0;
         rgb          <= BG_COLOR;
         hsync_out    <= 1'b1;
         vsync_out    <= 1'b1;
         video_on_out <= 1'b0;
      end else begin
         rom_addr     <= point_y + w_row;
         rom_en_digit <= w_en_d;
         rom_en_label <= w_en_l;
         rom_en_ind   <= w_en_i;
         r_col1       <= w_col;
         r_blank1     <= w_blank;
         r_hs1        <= r_hs0;
         r_vs1        <= r_vs0;
         r_vid1       <= r_vid0;
         r_col2       <= r_col1;
         r_blank2     <= r_blank1;
         r_hs2        <= r_hs1;
         r_vs2        <= r_vs1;
         r_vid2       <= r_vid1;
         rgb          <= (!r_blank2 && rom_data[w_bit]) ? FG_COLOR : BG_COLOR;
         hsync_out    <= r_hs2;
         vsync_out    <= r_vs2;
         video_on_out <= r_vid2;
      end
   end
endmodule
